div32_seq: RTL

//  - Iterative 32-bit divider: produces quotient and remainder by shift-and-subtract.
//  - Resolves one quotient bit per clock with a restoring-division loop.
//  - Sits beside the combinational 33-bit adder in the ALU/EX stage.
//  - Serves DIV/DIVU instructions through a start/busy/done handshake that the pipeline stalls on.

---
 rtl/div32_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div32_seq.sv
// Iterative restoring divider: one quotient bit per clock.
// A start/busy/done handshake lets the pipeline stall on DIV/DIVU.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         request, sampled only in IDLE while done is low
//   dividend      numerator, captured on an accepted start
//   divisor       denominator, captured on an accepted start
//   sgn           (DIV32_SIGNED_EN only) signed operation, captured with operands
//   busy          high from the cycle after accept until done
//   done          single-cycle pulse, results valid
//   quotient      held from done until the next accepted start
//   remainder     held from done until the next accepted start
//   div_zero      divisor was zero; held with the results
//
// Optional feature: define DIV32_SIGNED_EN to add signed division.
module div32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (always < divisor)
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             busy_d, done_d, dz_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic [WIDTH:0]   r_shift, r_diff;
  logic [WIDTH-1:0] a_load, b_load;

`ifdef DIV32_SIGNED_EN
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV32_SIGNED_EN
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dvd_raw_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      busy      <= busy_d;
      done      <= done_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      div_zero  <= dz_d;
`ifdef DIV32_SIGNED_EN
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dvd_raw_q <= dvd_raw_d;
`endif
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    busy_d      = busy;
    done_d      = 1'b0;
    quotient_d  = quotient;
    remainder_d = remainder;
    dz_d        = div_zero;
`ifdef DIV32_SIGNED_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dvd_raw_d   = dvd_raw_q;
    a_load      = (sgn && dividend[WIDTH-1]) ? WIDTH'(WIDTH'(0) - dividend) : dividend;
    b_load      = (sgn && divisor[WIDTH-1])  ? WIDTH'(WIDTH'(0) - divisor)  : divisor;
`else
    a_load      = dividend;
    b_load      = divisor;
`endif
    // One restoring step: shift in the next dividend bit, trial-subtract
    r_shift     = {rem_q, quo_q[WIDTH-1]};
    r_diff      = r_shift - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        // start during the done cycle is ignored; taken on the following cycle
        if (start && !done) begin
          quo_d  = a_load;
          dvs_d  = b_load;
          rem_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          dz_d   = (divisor == '0);
`ifdef DIV32_SIGNED_EN
          q_neg_d   = sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d   = sgn && dividend[WIDTH-1];
          dvd_raw_d = dividend;
`endif
          state_d = (divisor == '0) ? S_FIN : S_CALC;
        end
      end

      S_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~r_diff[WIDTH]};
        rem_d = r_diff[WIDTH] ? r_shift[WIDTH-1:0] : r_diff[WIDTH-1:0];
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_LAST) state_d = S_FIN;
      end

      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (div_zero) begin
          // Operand register still holds the unshifted dividend here
          quotient_d  = '1;
`ifdef DIV32_SIGNED_EN
          remainder_d = dvd_raw_q;
`else
          remainder_d = quo_q;
`endif
        end else begin
`ifdef DIV32_SIGNED_EN
          quotient_d  = q_neg_q ? WIDTH'(WIDTH'(0) - quo_q) : quo_q;
          remainder_d = r_neg_q ? WIDTH'(WIDTH'(0) - rem_q) : rem_q;
`else
          quotient_d  = quo_q;
          remainder_d = rem_q;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
